seq_cla_adder: RTL

Multi-cycle, width-parametrised adder/subtractor built from a single 4-bit carry-lookahead slice reused once per cycle. Operands are latched on `start`, processed one 4-bit chunk per clock (LSB first) with the carry held in a register between chunks, and the result is published with a one-cycle `done` pulse. It is the area-lean arithmetic unit for wide datapath operations in the processor, where a full-width CLA is not justified.

---
 rtl/seq_cla_adder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/seq_cla_adder.sv
// seq_cla_adder: multi-cycle adder/subtractor that reuses one 4-bit carry-lookahead slice.
//
// Operands are latched on start. One 4-bit chunk is processed per clock, LSB first, and the
// carry is held in a register between chunks. The result is published with a one-cycle done
// pulse. Latency is WIDTH/4 cycles. The critical path is one 4-bit CLA plus the carry register,
// whatever WIDTH is.
//
// Parameters
//   WIDTH  operand width in bits; must be a multiple of 4 and at least 4
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request a new operation (sampled only when idle)
//   inA    in   operand A
//   inB    in   operand B
//   cIn    in   carry-in (add only)
//   sub    in   0: A+B+cIn, 1: A-B (as A+~B+1)
//   busy   out  operation in progress
//   done   out  one-cycle pulse when sum/cOut/ofl update
//   sum    out  last completed result
//   cOut   out  carry out of the MSB (1 = no borrow when subtracting)
//   ofl    out  two's-complement overflow
//
// Optional feature
//   SEQ_CLA_SAT_EN  when defined, a signed overflow loads sum with the signed saturation value
//                   selected by A's MSB. ofl and cOut still report the raw conditions.

module seq_cla_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cIn,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cOut,
  output logic             ofl
);

  localparam int unsigned NumChunks = WIDTH / 4;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  state_e           state_q, state_d;
  // Operand registers shift right by one chunk per cycle, so the active chunk is always [3:0].
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  // Chunk sums enter at the top and shift down; after the last chunk the result is in order.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ofl_q, ofl_d;

  // 4-bit carry-lookahead slice
  logic [3:0]       chunk_a, chunk_b;
  logic [3:0]       gen, prop;
  logic [4:0]       carry;
  logic [3:0]       chunk_sum;

  always_comb begin
    chunk_a  = opa_q[3:0];
    chunk_b  = opb_q[3:0];
    gen      = chunk_a & chunk_b;
    prop     = chunk_a ^ chunk_b;
    carry[0] = carry_q;
    carry[1] = gen[0] | (prop[0] & carry[0]);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry[0]);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & carry[0]);
    carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & carry[0]);
    chunk_sum = prop ^ carry[3:0];
  end

  // Accumulator after absorbing the current chunk; also the full wrapped result on the last one.
  logic [WIDTH+3:0] acc_ext;
  logic [WIDTH-1:0] acc_next;
  logic             last_chunk;
  logic             chunk_ofl;
  logic [WIDTH-1:0] result;

  always_comb begin
    acc_ext    = {chunk_sum, acc_q};
    acc_next   = acc_ext[WIDTH+3:4];
    last_chunk = (cnt_q == CntW'(NumChunks - 1));
    // On the last chunk, carry[3] is the carry into bit WIDTH-1.
    chunk_ofl  = carry[3] ^ carry[4];
  end

`ifdef SEQ_CLA_SAT_EN
  logic [WIDTH-1:0] sat_val;

  always_comb begin
    // On the last chunk chunk_a[3] is A's MSB; overflow is only possible when A and B' agree.
    sat_val = {chunk_a[3], {(WIDTH - 1){~chunk_a[3]}}};
    result  = chunk_ofl ? sat_val : acc_next;
  end
`else
  always_comb begin
    result = acc_next;
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ofl_d   = ofl_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          opa_d   = inA;
          opb_d   = sub ? ~inB : inB;
          carry_d = sub ? 1'b1 : cIn;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        opa_d   = opa_q >> 4;
        opb_d   = opb_q >> 4;
        acc_d   = acc_next;
        carry_d = carry[4];
        cnt_d   = cnt_q + CntW'(1);
        if (last_chunk) begin
          sum_d   = result;
          cout_d  = carry[4];
          ofl_d   = chunk_ofl;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ofl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ofl_q   <= ofl_d;
    end
  end

  always_comb begin
    busy = (state_q == StBusy);
    done = done_q;
    sum  = sum_q;
    cOut = cout_q;
    ofl  = ofl_q;
  end

endmodule
